// File: rtl/vga_sprite_multi_core_if.sv
// rtl/vga_sprite_multi_core_if.sv - video slot register/bitmap bus
interface vga_sprite_multi_core_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, write, read, addr, wr_data, input rd_data);
  modport slave  (input cs, write, read, addr, wr_data, output rd_data);
endinterface

// File: rtl/vga_sprite_multi_core.sv
// rtl/vga_sprite_multi_core.sv - multi-sprite overlay with shadowed registers and 2-stage pixel pipeline
module vga_sprite_multi_core #(
  parameter int N_SPRITE   = 20,
  parameter int CD         = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int KEY_COLOR  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  input  logic [CD-1:0]          si_rgb,
  output logic [CD-1:0]          so_rgb,
  vga_sprite_multi_core_if.slave bus
);
  // image-select width; ctrl[5:2] is truncated to this many bits
  localparam int IW = ADDR_WIDTH - 8;

  logic [1:0]          r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [10:0]         r_sx [N_SPRITE];
  logic [10:0]         r_sy [N_SPRITE];
  logic [5:0]          r_sc [N_SPRITE];
  logic [10:0]         r_ax [N_SPRITE];
  logic [10:0]         r_ay [N_SPRITE];
  logic [5:0]          r_ac [N_SPRITE];
  logic                r_bypass;
  logic                r_mode;
  logic [CD-1:0]       r_pal [3];
  logic [N_SPRITE-1:0] r_coll;
  logic [15:0]         r_fcnt;
  logic [10:0]         r_px;
  logic [10:0]         r_py;
  logic [1:0]          r_pix [N_SPRITE];
  logic [CD-1:0]       r_si1;

  logic [1:0]          w_pix [N_SPRITE];
  logic [7:0]          w_ra;
  logic                w_wr_ram;
  logic                w_wr_reg;
  logic                w_rd_reg;
  logic                w_clr;
  logic                w_fs;
  logic [31:0]         w_rd;
  logic [N_SPRITE-1:0] w_nz;
  logic [1:0]          w_win;
  logic                w_multi;
  logic [CD-1:0]       w_col;
  logic                w_unused;

  assign w_ra     = bus.addr[7:0];
  assign w_wr_ram = bus.cs & bus.write & ~bus.addr[13];
  assign w_wr_reg = bus.cs & bus.write & bus.addr[13];
  assign w_rd_reg = bus.cs & bus.read & bus.addr[13];
  assign w_clr    = w_wr_reg && (w_ra == 8'd9);
  // frame start: entering (0,0) from any other coordinate; tracker resets to (0,0)
  assign w_fs     = (x == 11'd0) && (y == 11'd0) && !((r_px == 11'd0) && (r_py == 11'd0));
  assign w_unused = &{1'b0, bus.addr, bus.wr_data, 32'(KEY_COLOR)};

  // bitmap RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_ram) r_mem[bus.addr[ADDR_WIDTH-1:0]] <= bus.wr_data[1:0];
  end

  // per-sprite hit test and bitmap fetch (stage 1 input)
  for (genvar g = 0; g < N_SPRITE; g++) begin : g_spr
    logic [10:0]           w_dx;
    logic [10:0]           w_dy;
    logic [3:0]            w_c;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_dx     = x - r_ax[g];
    assign w_dy     = y - r_ay[g];
    assign w_hit    = r_ac[g][0] && (w_dx[10:4] == 7'd0) && (w_dy[10:4] == 7'd0);
    assign w_c      = r_ac[g][1] ? ~w_dx[3:0] : w_dx[3:0];
    assign w_addr   = {r_ac[g][2 +: IW], w_dy[3:0], w_c};
    assign w_pix[g] = w_hit ? r_mem[w_addr] : 2'd0;
  end

  // registers, shadow/active sprite state, frame counter and commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bypass <= 1'b0;
      r_mode   <= 1'b0;
      r_fcnt   <= 16'd0;
      r_px     <= 11'd0;
      r_py     <= 11'd0;
      for (int p = 0; p < 3; p++) r_pal[p] <= '0;
      for (int i = 0; i < N_SPRITE; i++) begin
        r_sx[i] <= '0; r_sy[i] <= '0; r_sc[i] <= '0;
        r_ax[i] <= '0; r_ay[i] <= '0; r_ac[i] <= '0;
      end
    end else begin
      r_px <= x;
      r_py <= y;
      if (w_fs) begin
        r_fcnt <= r_fcnt + 16'd1;
        for (int i = 0; i < N_SPRITE; i++) begin
          r_ax[i] <= r_sx[i]; r_ay[i] <= r_sy[i]; r_ac[i] <= r_sc[i];
        end
      end
      if (w_wr_reg) begin
        case (w_ra)
          8'd0:    r_bypass <= bus.wr_data[0];
          8'd1:    r_pal[0] <= bus.wr_data[CD-1:0];
          8'd2:    r_pal[1] <= bus.wr_data[CD-1:0];
          8'd3:    r_pal[2] <= bus.wr_data[CD-1:0];
          8'd4:    r_mode   <= bus.wr_data[0];
          default: ;
        endcase
        // immediate mode writes active alongside shadow, overriding a same-edge commit
        for (int i = 0; i < N_SPRITE; i++) begin
          if (w_ra == 8'(32 + 4*i)) begin
            r_sx[i] <= bus.wr_data[10:0];
            if (r_mode) r_ax[i] <= bus.wr_data[10:0];
          end
          if (w_ra == 8'(33 + 4*i)) begin
            r_sy[i] <= bus.wr_data[10:0];
            if (r_mode) r_ay[i] <= bus.wr_data[10:0];
          end
          if (w_ra == 8'(34 + 4*i)) begin
            r_sc[i] <= bus.wr_data[5:0];
            if (r_mode) r_ac[i] <= bus.wr_data[5:0];
          end
        end
      end
    end
  end

  // register read mux; unmapped addresses read as zero
  always_comb begin
    w_rd = '0;
    case (w_ra)
      8'd0:    w_rd[0]       = r_bypass;
      8'd1:    w_rd[CD-1:0]  = r_pal[0];
      8'd2:    w_rd[CD-1:0]  = r_pal[1];
      8'd3:    w_rd[CD-1:0]  = r_pal[2];
      8'd4:    w_rd[0]       = r_mode;
      8'd8:    w_rd[N_SPRITE-1:0] = r_coll;
      8'd10:   w_rd[15:0]    = r_fcnt;
      default: ;
    endcase
    for (int i = 0; i < N_SPRITE; i++) begin
      if (w_ra == 8'(32 + 4*i)) w_rd[10:0] = r_sx[i];
      if (w_ra == 8'(33 + 4*i)) w_rd[10:0] = r_sy[i];
      if (w_ra == 8'(34 + 4*i)) w_rd[5:0]  = r_sc[i];
    end
  end

  // stage 2 priority: descending scan so the lowest opaque sprite is written last
  always_comb begin
    w_nz  = '0;
    w_win = 2'd0;
    for (int i = N_SPRITE - 1; i >= 0; i--) begin
      if (r_pix[i] != 2'd0) begin
        w_nz[i] = 1'b1;
        w_win   = r_pix[i];
      end
    end
  end

  // two or more opaque sprites when clearing the lowest set bit leaves something
  assign w_multi = |(w_nz & (w_nz - N_SPRITE'(1)));

  // palette lookup for the winning pixel value, stream pixel when none
  always_comb begin
    case (w_win)
      2'd1:    w_col = r_pal[0];
      2'd2:    w_col = r_pal[1];
      2'd3:    w_col = r_pal[2];
      default: w_col = r_si1;
    endcase
  end

  // pixel pipeline, sticky collision mask and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SPRITE; i++) r_pix[i] <= 2'd0;
      r_si1       <= '0;
      so_rgb      <= '0;
      r_coll      <= '0;
      bus.rd_data <= '0;
    end else begin
      for (int i = 0; i < N_SPRITE; i++) r_pix[i] <= w_pix[i];
      r_si1  <= si_rgb;
      so_rgb <= r_bypass ? r_si1 : w_col;
      if (w_clr)        r_coll <= w_multi ? w_nz : '0;
      else if (w_multi) r_coll <= r_coll | w_nz;
      if (w_rd_reg) bus.rd_data <= w_rd;
    end
  end
endmodule

// File: tb/tb_vga_sprite_multi_core.sv
// tb/tb_vga_sprite_multi_core.sv - scoreboard bench for vga_sprite_multi_core
module tb_vga_sprite_multi_core;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x;
  logic [10:0] y;
  logic [11:0] si_rgb;
  logic [11:0] so_rgb;

  vga_sprite_multi_core_if bus_if();

  vga_sprite_multi_core dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .si_rgb(si_rgb), .so_rgb(so_rgb), .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic [11:0] si;
    logic [11:0] e;
  } px_t;

  px_t         stim[$];
  logic [11:0] sb[$];
  int          n_run = 0;
  int          n_fail = 0;
  int          n_frames = 0;
  logic [31:0] d;
  logic [11:0] e;
  px_t         s;
  int          n;

  localparam logic [11:0] PAL1 = 12'hF00;
  localparam logic [11:0] PAL2 = 12'h0F0;
  localparam logic [11:0] PAL3 = 12'h00F;
  localparam logic [13:0] REG  = 14'h2000;

  function automatic logic [13:0] spr(input int i, input int f);
    return REG + 14'(32 + 4*i + f);
  endfunction

  task automatic bus_wr(input logic [13:0] a, input logic [31:0] v);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.write = 1'b1; bus_if.addr = a; bus_if.wr_data = v;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.write = 1'b0;
  endtask

  task automatic bus_rd(input logic [13:0] a, output logic [31:0] v);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.read = 1'b1; bus_if.addr = a;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.read = 1'b0;
    v = bus_if.rd_data;
  endtask

  task automatic frame_start();
    @(negedge clk);
    x = 11'd0; y = 11'd0;
    @(negedge clk);
    x = 11'd1000; y = 11'd1000;
    n_frames++;
  endtask

  task automatic add_px(input int px, input int py, input logic [11:0] si, input logic [11:0] ex);
    s.px = 11'(px); s.py = 11'(py); s.si = si; s.e = ex;
    stim.push_back(s);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x = 11'd0; y = 11'd0; si_rgb = 12'h0;
    bus_if.cs = 1'b0; bus_if.write = 1'b0; bus_if.read = 1'b0;
    bus_if.addr = '0; bus_if.wr_data = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n_run++;
    if (so_rgb !== 12'h0) begin n_fail++; $display("FAIL reset_so: got %h want 000", so_rgb); end
    n_run++;
    if (bus_if.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", bus_if.rd_data); end
    repeat (3) @(negedge clk);
    bus_rd(REG + 14'd10, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d want 0", d); end
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_coll: got %h want 0", d); end
    bus_rd(spr(0, 0), d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_sx0: got %0d want 0", d); end
    @(negedge clk);
    x = 11'd1000; y = 11'd1000;
  endtask

  task automatic test_basic();
    for (int a = 0; a < 768; a++) begin
      if (a < 256)      bus_wr(14'(a), 32'd1);
      else if (a < 512) bus_wr(14'(a), ((a % 16) == 0) ? 32'd2 : 32'd1);
      else              bus_wr(14'(a), 32'd2);
    end
    bus_wr(REG + 14'd1, 32'(PAL1));
    bus_wr(REG + 14'd2, 32'(PAL2));
    bus_wr(REG + 14'd3, 32'(PAL3));
    bus_wr(spr(0, 0), 32'd100);
    bus_wr(spr(0, 1), 32'd50);
    bus_wr(spr(0, 2), 32'h01);
    add_px(100, 50, 12'h0AA, 12'h0AA);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL basic_precommit px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    frame_start();
    bus_rd(REG + 14'd10, d);
    n_run++;
    if (d !== 32'(n_frames)) begin n_fail++; $display("FAIL basic_fcnt: got %0d want %0d", d, n_frames); end
    add_px(100, 50, 12'h0AA, PAL1);
    add_px(116, 50, 12'h0AA, 12'h0AA);
    add_px(115, 65, 12'h123, PAL1);
    add_px(99, 50, 12'h456, 12'h456);
    add_px(100, 66, 12'h789, 12'h789);
    add_px(100, 49, 12'h0BC, 12'h0BC);
    add_px(107, 60, 12'h0DE, PAL1);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL basic_hit px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
  endtask

  task automatic test_shadow();
    bus_wr(spr(0, 0), 32'd200);
    bus_rd(spr(0, 0), d);
    n_run++;
    if (d !== 32'd200) begin n_fail++; $display("FAIL shadow_readback: got %0d want 200", d); end
    add_px(100, 50, 12'h0AA, PAL1);
    add_px(200, 50, 12'h0AA, 12'h0AA);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL shadow_pending px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    frame_start();
    add_px(200, 50, 12'h011, PAL1);
    add_px(100, 50, 12'h055, 12'h055);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL shadow_commit px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_wr(REG + 14'd4, 32'd1);
    bus_wr(spr(0, 0), 32'd300);
    add_px(300, 50, 12'h022, PAL1);
    add_px(200, 50, 12'h033, 12'h033);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL shadow_immediate px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_wr(REG + 14'd4, 32'd0);
    bus_wr(spr(0, 0), 32'd100);
    frame_start();
  endtask

  task automatic test_priority_collision();
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL coll_idle: got %h want 0", d); end
    bus_wr(spr(1, 0), 32'd108);
    bus_wr(spr(1, 1), 32'd50);
    bus_wr(spr(1, 2), 32'h09);
    frame_start();
    add_px(110, 50, 12'h001, PAL1);
    add_px(116, 50, 12'h002, PAL2);
    add_px(123, 50, 12'h003, PAL2);
    add_px(124, 50, 12'h004, 12'h004);
    add_px(100, 50, 12'h005, PAL1);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL priority px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL coll_set: got %h want 3", d); end
    bus_wr(REG + 14'd9, 32'd0);
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL coll_clear: got %h want 0", d); end
    add_px(112, 52, 12'h006, PAL1);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL priority_again px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL coll_reset: got %h want 3", d); end
    bus_wr(spr(20, 0), 32'd55);
    bus_rd(spr(20, 0), d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_sprite: got %h want 0", d); end
    bus_wr(REG + 14'h23, 32'd7);
    bus_rd(REG + 14'h23, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_field: got %h want 0", d); end
    bus_rd(spr(1, 1), d);
    n_run++;
    if (d !== 32'd50) begin n_fail++; $display("FAIL read_sy1: got %0d want 50", d); end
  endtask

  task automatic test_mirror();
    bus_wr(spr(1, 2), 32'h00);
    bus_wr(spr(0, 2), 32'h07);
    frame_start();
    add_px(115, 50, 12'h010, PAL2);
    add_px(100, 50, 12'h020, PAL1);
    add_px(107, 61, 12'h030, PAL1);
    add_px(115, 61, 12'h040, PAL2);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL mirror px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_wr(spr(0, 2), 32'h05);
    frame_start();
    add_px(100, 50, 12'h050, PAL2);
    add_px(115, 50, 12'h060, PAL1);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL no_mirror px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
  endtask

  task automatic test_bypass_reset();
    bus_wr(REG + 14'd0, 32'd1);
    add_px(100, 50, 12'h123, 12'h123);
    add_px(108, 55, 12'h456, 12'h456);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL bypass px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
    bus_rd(REG + 14'd10, d);
    n_run++;
    if (d !== 32'(n_frames)) begin n_fail++; $display("FAIL fcnt_pre_reset: got %0d want %0d", d, n_frames); end
    @(negedge clk);
    x = 11'd100; y = 11'd50; si_rgb = 12'h777;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_run++;
    if (so_rgb !== 12'h0) begin n_fail++; $display("FAIL async_reset_so: got %h want 000", so_rgb); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(REG + 14'd10, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_fcnt: got %0d want 0", d); end
    bus_rd(REG + 14'd8, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_coll: got %h want 0", d); end
    bus_rd(REG + 14'd1, d);
    n_run++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_pal1: got %h want 0", d); end
    bus_wr(REG + 14'd4, 32'd1);
    bus_wr(REG + 14'd2, 32'(PAL2));
    bus_wr(spr(0, 0), 32'd100);
    bus_wr(spr(0, 1), 32'd50);
    bus_wr(spr(0, 2), 32'h05);
    add_px(100, 50, 12'h111, PAL2);
    add_px(101, 50, 12'h222, 12'h000);
    add_px(90, 50, 12'h333, 12'h333);
    n = stim.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = sb.pop_front(); n_run++;
        if (so_rgb !== e) begin n_fail++; $display("FAIL ram_retained px%0d: got %h want %h", k-2, so_rgb, e); end
      end
      if (k < n) begin s = stim.pop_front(); x = s.px; y = s.py; si_rgb = s.si; sb.push_back(s.e); end
      else begin x = 11'd1000; y = 11'd1000; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_priority_collision();
    test_mirror();
    test_bypass_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
